// File: rtl/crc_pkg.sv
// Shared definitions for the multi-channel APB CRC accelerator: register map,
// CFG field layout, bus FSM states and width normalisation.
package crc_pkg;

  localparam logic [4:0] OFF_DATA   = 5'h00;
  localparam logic [4:0] OFF_CRC    = 5'h04;
  localparam logic [4:0] OFF_POLY   = 5'h08;
  localparam logic [4:0] OFF_INIT   = 5'h0C;
  localparam logic [4:0] OFF_CFG    = 5'h10;
  localparam logic [4:0] OFF_STATUS = 5'h14;

  localparam int CH_STRIDE      = 32'h20;
  localparam int CH_LSB         = 5;
  localparam int CH_W           = 3;
  localparam int CFG_WIDTH_LSB  = 0;
  localparam int CFG_WIDTH_W    = 5;
  localparam int CFG_RELOAD_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } bus_state_e;

  // 0 or anything wider than the engine means "full width"
  function automatic logic [5:0] eff_width(input logic [4:0] w, input int crc_w);
    if (w == 5'd0 || int'(w) > crc_w) return 6'(crc_w);
    return {1'b0, w};
  endfunction

endpackage

// File: rtl/crc_serial_core.sv
// Bit-serial MSB-first CRC engine: one byte takes 8 cycles, width/poly are
// captured at the start of each byte so register writes never disturb it.
module crc_serial_core #(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] CRC_RST = '0
) (
  input  logic             p_clk_i,
  input  logic             p_rst_i,
  input  logic [CRC_W-1:0] poly,
  input  logic [CRC_W-1:0] init,
  input  logic [5:0]       width,
  input  logic             load_init,
  input  logic [7:0]       data_byte,
  input  logic             byte_valid,
  output logic [CRC_W-1:0] crc,
  output logic             busy
);

  logic [CRC_W-1:0] crc_q, poly_q, mask_q, top_q;
  logic [CRC_W-1:0] mask_w, top_w, crc_step;
  logic [7:0]       sh_q;
  logic [2:0]       cnt_q;
  logic             busy_q, fb;

  always_comb begin
    mask_w = '0;
    for (int i = 0; i < CRC_W; i++) mask_w[i] = (i < int'(width));
    top_w = mask_w & ~(mask_w >> 1);
  end

  // top_q is one-hot on bit W-1 of the width captured for this byte
  assign fb       = (|(crc_q & top_q)) ^ sh_q[7];
  assign crc_step = ((crc_q << 1) & mask_q) ^ (fb ? poly_q : '0);

  always_ff @(posedge p_clk_i or posedge p_rst_i) begin
    if (p_rst_i) begin
      crc_q  <= CRC_RST;
      poly_q <= '0;
      mask_q <= '0;
      top_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      crc_q <= crc_step;
      sh_q  <= {sh_q[6:0], 1'b0};
      cnt_q <= cnt_q - 3'd1;
      if (cnt_q == 3'd0) busy_q <= 1'b0;
    end else if (byte_valid) begin
      crc_q  <= crc_q & mask_w;
      poly_q <= poly & mask_w;
      mask_q <= mask_w;
      top_q  <= top_w;
      sh_q   <= data_byte;
      cnt_q  <= 3'd7;
      busy_q <= 1'b1;
    end else if (load_init) begin
      crc_q <= init;
    end
  end

  assign crc  = crc_q & mask_w;
  assign busy = busy_q;

endmodule

// File: rtl/crc_apb_multi.sv
// APB slave front end for CH_NUM independent CRC channels: decode, register
// file, error responses and the wait-state FSM that stalls on busy channels.
module crc_apb_multi
  import crc_pkg::*;
#(
  parameter int          CH_NUM    = 2,
  parameter int          CRC_W     = 16,
  parameter logic [31:0] POLY_RST  = 32'h07,
  parameter logic [31:0] INIT_RST  = 32'h00,
  parameter int          WIDTH_RST = 8
) (
  input  logic        p_clk_i,
  input  logic        p_rst_i,
  input  logic        p_sel_i,
  input  logic        p_enable_i,
  input  logic        p_we_i,
  input  logic [31:0] p_adr_i,
  input  logic [31:0] p_dat_i,
  output logic [31:0] p_dat_o,
  output logic        p_ready,
  output logic        p_slverr
);

  localparam logic [5:0] WIDTH_INI = eff_width(5'(WIDTH_RST), CRC_W);

  bus_state_e state_q, state_d;

  logic [CH_W-1:0] ch;
  logic [4:0]      off;
  logic            mapped, err, stall, fire, act, ch_busy;
  logic            is_data_wr, is_crc_rd, is_reload_wr;

  logic [CH_NUM-1:0][CRC_W-1:0] poly_q, init_q, crc_out;
  logic [CH_NUM-1:0][5:0]       width_q;
  logic [CH_NUM-1:0]            busy, byte_valid, load_init, ch_hit;

  logic [CRC_W-1:0] poly_sel, init_sel, crc_sel;
  logic [5:0]       width_sel;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign ch  = p_adr_i[CH_LSB +: CH_W];
  assign off = p_adr_i[4:0];
  assign unused_bits = ^{p_adr_i[31:CH_LSB+CH_W], p_dat_i, width_sel[5]};

  always_comb begin
    ch_hit    = '0;
    poly_sel  = '0;
    init_sel  = '0;
    crc_sel   = '0;
    width_sel = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      ch_hit[i] = (ch == CH_W'(i));
      if (ch_hit[i]) begin
        poly_sel  = poly_q[i];
        init_sel  = init_q[i];
        crc_sel   = crc_out[i];
        width_sel = width_q[i];
      end
    end
    ch_busy = |(ch_hit & busy);
  end

  always_comb begin
    mapped = 1'b0;
    case (off)
      OFF_DATA, OFF_CRC, OFF_POLY, OFF_INIT, OFF_CFG, OFF_STATUS: mapped = 1'b1;
      default: mapped = 1'b0;
    endcase
  end

  assign is_data_wr   = p_we_i & (off == OFF_DATA);
  assign is_crc_rd    = !p_we_i & (off == OFF_CRC);
  assign is_reload_wr = p_we_i & (off == OFF_CFG) & p_dat_i[CFG_RELOAD_BIT];

  assign err = !(|ch_hit) | !mapped
             | (p_we_i & ((off == OFF_CRC) | (off == OFF_STATUS)))
             | (!p_we_i & (off == OFF_DATA));
  assign stall = ch_busy & (is_data_wr | is_crc_rd | is_reload_wr);

  always_ff @(posedge p_clk_i or posedge p_rst_i) begin
    if (p_rst_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (p_sel_i && p_enable_i) state_d = ST_ACCESS;
      ST_ACCESS,
      ST_WAIT: begin
        if (!(p_sel_i && p_enable_i)) state_d = ST_IDLE;
        else if (!stall)             state_d = ST_DONE;
        else                         state_d = ST_WAIT;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Completion is signalled in the cycle the FSM commits to DONE, giving one
  // wait state uncontended and ready on the first cycle a stalled channel frees.
  always_comb begin
    fire = 1'b0;
    case (state_q)
      ST_ACCESS, ST_WAIT: fire = p_sel_i & p_enable_i & !stall;
      default:            fire = 1'b0;
    endcase
    act      = fire & !err;
    p_ready  = fire;
    p_slverr = fire & err;
    p_dat_o  = (act && !p_we_i) ? rdata : 32'h0;
  end

  always_comb begin
    rdata = 32'h0;
    case (off)
      OFF_CRC:    rdata = 32'(crc_sel);
      OFF_POLY:   rdata = 32'(poly_sel);
      OFF_INIT:   rdata = 32'(init_sel);
      OFF_CFG:    rdata[CFG_WIDTH_LSB +: CFG_WIDTH_W] = width_sel[4:0];
      OFF_STATUS: rdata[0] = ch_busy;
      default:    rdata = 32'h0;
    endcase
  end

  assign byte_valid = ch_hit & {CH_NUM{act & is_data_wr}};
  assign load_init  = ch_hit & {CH_NUM{act & (is_crc_rd | is_reload_wr)}};

  always_ff @(posedge p_clk_i or posedge p_rst_i) begin
    if (p_rst_i) begin
      for (int i = 0; i < CH_NUM; i++) begin
        poly_q[i]  <= POLY_RST[CRC_W-1:0];
        init_q[i]  <= INIT_RST[CRC_W-1:0];
        width_q[i] <= WIDTH_INI;
      end
    end else if (act && p_we_i) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (ch_hit[i]) begin
          case (off)
            OFF_POLY: poly_q[i]  <= p_dat_i[CRC_W-1:0];
            OFF_INIT: init_q[i]  <= p_dat_i[CRC_W-1:0];
            OFF_CFG:  width_q[i] <= eff_width(p_dat_i[CFG_WIDTH_LSB +: CFG_WIDTH_W], CRC_W);
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    crc_serial_core #(
      .CRC_W  (CRC_W),
      .CRC_RST(INIT_RST[CRC_W-1:0])
    ) u_core (
      .p_clk_i   (p_clk_i),
      .p_rst_i   (p_rst_i),
      .poly      (poly_q[g]),
      .init      (init_q[g]),
      .width     (width_q[g]),
      .load_init (load_init[g]),
      .data_byte (p_dat_i[7:0]),
      .byte_valid(byte_valid[g]),
      .crc       (crc_out[g]),
      .busy      (busy[g])
    );
  end

endmodule
